// File: rtl/shift_issue_queue.sv
// Shift-unit reservation station: DP entries with operand wakeup from the writeback
// bus, age-matrix oldest-ready select, and a registered issue port to the shift unit.

module shift_iq_entry #(
   parameter int TW = 7,
   parameter int DW = 3 + 7 + 64 + 64 + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          alloc,
   input  logic          issue,
   input  logic [2:0]    fun,
   input  logic [TW-1:0] rd0,
   input  logic [TW-1:0] rs1,
   input  logic [TW-1:0] rs2,
   input  logic          rs1_rdy,
   input  logic          rs2_rdy,
   input  logic [63:0]   op1,
   input  logic [63:0]   op2,
   input  logic          is32w,
   input  logic          wb_vaild,
   input  logic [TW-1:0] wb_tag,
   input  logic [63:0]   wb_data,
   output logic          valid,
   output logic          ready,
   output logic [DW-1:0] payload
);

   logic [2:0]    fun_r;
   logic [TW-1:0] rd0_r, rs1_r, rs2_r;
   logic          r1_r, r2_r, w_r;
   logic [63:0]   op1_r, op2_r;
   logic          byp1, byp2, wake1, wake2;

   // byp*: writeback landing in the same cycle as the dispatch that needs it
   assign byp1  = wb_vaild && (wb_tag == rs1);
   assign byp2  = wb_vaild && (wb_tag == rs2);
   assign wake1 = wb_vaild && valid && !r1_r && (wb_tag == rs1_r);
   assign wake2 = wb_vaild && valid && !r2_r && (wb_tag == rs2_r);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         fun_r <= '0;
         rd0_r <= '0;
         rs1_r <= '0;
         rs2_r <= '0;
         r1_r  <= 1'b0;
         r2_r  <= 1'b0;
         op1_r <= '0;
         op2_r <= '0;
         w_r   <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (alloc) begin
         valid <= 1'b1;
         fun_r <= fun;
         rd0_r <= rd0;
         rs1_r <= rs1;
         rs2_r <= rs2;
         w_r   <= is32w;
         r1_r  <= rs1_rdy || byp1;
         r2_r  <= rs2_rdy || byp2;
         op1_r <= (!rs1_rdy && byp1) ? wb_data : op1;
         op2_r <= (!rs2_rdy && byp2) ? wb_data : op2;
      end else begin
         if (issue) valid <= 1'b0;
         if (wake1) begin
            r1_r  <= 1'b1;
            op1_r <= wb_data;
         end
         if (wake2) begin
            r2_r  <= 1'b1;
            op2_r <= wb_data;
         end
      end
   end

   assign ready   = valid && r1_r && r2_r;
   assign payload = {fun_r, rd0_r, op1_r, op2_r, w_r};

endmodule

module shift_issue_queue #(
   parameter int DP = 4,
   parameter int RB = 2,
   parameter int DW = 3 + (5 + RB) + 64 + 64 + 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     flush,
   input  logic                     disp_vaild,
   output logic                     disp_ready,
   input  logic [2:0]               disp_fun,
   input  logic [5+RB-1:0]          disp_rd0,
   input  logic [5+RB-1:0]          disp_rs1,
   input  logic [5+RB-1:0]          disp_rs2,
   input  logic                     disp_rs1_rdy,
   input  logic                     disp_rs2_rdy,
   input  logic [63:0]              disp_op1,
   input  logic [63:0]              disp_op2,
   input  logic                     disp_is32w,
   input  logic                     wb_vaild,
   input  logic [5+RB-1:0]          wb_tag,
   input  logic [63:0]              wb_data,
   output logic                     shift_exeparam_vaild,
   output logic [DW-1:0]            shift_exeparam,
   output logic [$clog2(DP):0]      entry_cnt
);

   localparam int TW = 5 + RB;
   localparam int CW = $clog2(DP) + 1;

   logic [DP-1:0]          valid, rdy, sel, alloc, free_oh;
   logic [DP-1:0][DW-1:0]  pay;
   // older[i][j] = 1: entry j was dispatched before entry i
   logic [DP-1:0][DP-1:0]  older;
   logic [DW-1:0]          issue_bus;
   logic                   accept, issue_any;

   assign disp_ready = entry_cnt < CW'(DP);
   assign accept     = disp_vaild && disp_ready && !flush;
   // lowest clear bit of valid, as a one-hot
   assign free_oh    = ~valid & (valid + DP'(1));
   assign alloc      = accept ? free_oh : '0;

   for (genvar g = 0; g < DP; g++) begin : g_ent
      shift_iq_entry #(.TW(TW), .DW(DW)) u_ent (
         .clk      (CLK),
         .rst      (RST),
         .flush    (flush),
         .alloc    (alloc[g]),
         .issue    (sel[g]),
         .fun      (disp_fun),
         .rd0      (disp_rd0),
         .rs1      (disp_rs1),
         .rs2      (disp_rs2),
         .rs1_rdy  (disp_rs1_rdy),
         .rs2_rdy  (disp_rs2_rdy),
         .op1      (disp_op1),
         .op2      (disp_op2),
         .is32w    (disp_is32w),
         .wb_vaild (wb_vaild),
         .wb_tag   (wb_tag),
         .wb_data  (wb_data),
         .valid    (valid[g]),
         .ready    (rdy[g]),
         .payload  (pay[g])
      );
   end

   // A candidate wins when no other candidate is older than it
   always_comb begin
      sel       = '0;
      issue_bus = '0;
      for (int i = 0; i < DP; i++) begin
         sel[i] = rdy[i] && !(|(older[i] & rdy));
         if (sel[i]) issue_bus = issue_bus | pay[i];
      end
   end

   assign issue_any = |sel;

   always_ff @(posedge CLK) begin
      if (RST) begin
         entry_cnt            <= '0;
         shift_exeparam_vaild <= 1'b0;
         shift_exeparam       <= '0;
         older                <= '0;
      end else if (flush) begin
         entry_cnt            <= '0;
         shift_exeparam_vaild <= 1'b0;
         older                <= '0;
      end else begin
         entry_cnt            <= entry_cnt + CW'(accept) - CW'(issue_any);
         shift_exeparam_vaild <= issue_any;
         if (issue_any) shift_exeparam <= issue_bus;
         // new row: every live entry is older; new column: nobody is younger than it
         for (int i = 0; i < DP; i++)
            for (int j = 0; j < DP; j++)
               if (alloc[i]) older[i][j] <= valid[j];
               else if (alloc[j]) older[i][j] <= 1'b0;
      end
   end

   a_sel_onehot : assert property (@(posedge CLK) disable iff (RST) $onehot0(sel));
   a_cnt_match  : assert property (@(posedge CLK) disable iff (RST)
                                   entry_cnt == CW'($countones(valid)));

endmodule

// File: tb/tb_shift_issue_queue.sv
// Scenario bench for shift_issue_queue: expected issue payloads are queued at stimulus
// time and compared by a monitor whenever the DUT raises shift_exeparam_vaild.

module tb_shift_issue_queue;
   localparam int DP = 4;
   localparam int RB = 2;
   localparam int TW = 5 + RB;
   localparam int DW = 3 + TW + 64 + 64 + 1;

   logic          CLK, RST, flush, disp_vaild, disp_ready;
   logic [2:0]    disp_fun;
   logic [TW-1:0] disp_rd0, disp_rs1, disp_rs2, wb_tag;
   logic          disp_rs1_rdy, disp_rs2_rdy, disp_is32w, wb_vaild;
   logic [63:0]   disp_op1, disp_op2, wb_data;
   logic          shift_exeparam_vaild;
   logic [DW-1:0] shift_exeparam;
   logic [2:0]    entry_cnt;

   int vectors = 0;
   int miscompares = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;

   shift_issue_queue #(.DP(DP), .RB(RB)) dut (
      .CLK(CLK), .RST(RST), .flush(flush),
      .disp_vaild(disp_vaild), .disp_ready(disp_ready), .disp_fun(disp_fun),
      .disp_rd0(disp_rd0), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
      .disp_op1(disp_op1), .disp_op2(disp_op2), .disp_is32w(disp_is32w),
      .wb_vaild(wb_vaild), .wb_tag(wb_tag), .wb_data(wb_data),
      .shift_exeparam_vaild(shift_exeparam_vaild), .shift_exeparam(shift_exeparam),
      .entry_cnt(entry_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] mk(input logic [2:0] f, input logic [TW-1:0] rd,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic w);
      return {f, rd, a, b, w};
   endfunction

   // every issue must match the next queued expectation
   always @(posedge CLK) begin
      #1;
      if (RST === 1'b0 && shift_exeparam_vaild === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_issue: got bus=%h, required no issue", shift_exeparam);
         end else begin
            mon_exp = exp_q.pop_front();
            if (shift_exeparam !== mon_exp) begin
               miscompares++;
               $display("FAIL issue_bus: got %h, required %h", shift_exeparam, mon_exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr();
      disp_vaild = 1'b0;
      wb_vaild   = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic set_disp(input logic [2:0] f, input logic [TW-1:0] rd,
                           input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                           input logic r1, input logic r2,
                           input logic [63:0] a, input logic [63:0] b, input logic w);
      disp_vaild = 1'b1;  disp_fun = f;  disp_rd0 = rd;
      disp_rs1 = t1;  disp_rs2 = t2;  disp_rs1_rdy = r1;  disp_rs2_rdy = r2;
      disp_op1 = a;  disp_op2 = b;  disp_is32w = w;
   endtask

   task automatic set_wb(input logic [TW-1:0] t, input logic [63:0] d);
      wb_vaild = 1'b1;  wb_tag = t;  wb_data = d;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      clr();
      step();
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL reset_vaild: got %b, required 0", shift_exeparam_vaild); end
      vectors++; if (disp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", disp_ready); end
      vectors++; if (entry_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d, required 0", entry_cnt); end
      vectors++; if (shift_exeparam !== '0) begin miscompares++; $display("FAIL reset_bus: got %h, required 0", shift_exeparam); end
      RST = 1'b0;
      step();
   endtask

   task automatic test_dispatch();
      logic [DW-1:0] e;
      e = mk(3'b100, 7'd9, 64'd1, 64'd4, 1'b0);
      set_disp(3'b100, 7'd9, 7'd1, 7'd2, 1'b1, 1'b1, 64'd1, 64'd4, 1'b0);
      exp_q.push_back(e);
      step(); clr();
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL disp_t1_vaild: got %b, required 0", shift_exeparam_vaild); end
      vectors++; if (entry_cnt !== 3'd1) begin miscompares++; $display("FAIL disp_t1_cnt: got %0d, required 1", entry_cnt); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL disp_t2_vaild: got %b, required 1", shift_exeparam_vaild); end
      vectors++; if (entry_cnt !== 3'd0) begin miscompares++; $display("FAIL disp_t2_cnt: got %0d, required 0", entry_cnt); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL disp_t3_vaild: got %b, required 0", shift_exeparam_vaild); end
      vectors++; if (shift_exeparam !== e) begin miscompares++; $display("FAIL disp_bus_hold: got %h, required %h", shift_exeparam, e); end
   endtask

   task automatic test_wakeup();
      set_disp(3'b001, 7'd10, 7'd5, 7'd6, 1'b0, 1'b1, 64'hdead, 64'd3, 1'b0);
      step(); clr();
      for (int k = 0; k < 3; k++) begin
         // a wb for the already-ready rs2 must not disturb op2
         if (k == 0) set_wb(7'd6, 64'hbad);
         step(); clr();
         vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL wake_early_issue: got %b, required 0", shift_exeparam_vaild); end
      end
      set_wb(7'd5, 64'h80);
      exp_q.push_back(mk(3'b001, 7'd10, 64'h80, 64'd3, 1'b0));
      step(); clr();
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL wake_u1_vaild: got %b, required 0", shift_exeparam_vaild); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL wake_u2_vaild: got %b, required 1", shift_exeparam_vaild); end
      step();
   endtask

   task automatic test_age();
      set_disp(3'b010, 7'd11, 7'd1, 7'd12, 1'b1, 1'b0, 64'd7, 64'd0, 1'b0);
      step();
      set_disp(3'b100, 7'd13, 7'd2, 7'd3, 1'b1, 1'b1, 64'h55, 64'd2, 1'b1);
      exp_q.push_back(mk(3'b100, 7'd13, 64'h55, 64'd2, 1'b1));
      step(); clr();
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL age_b_early: got %b, required 0", shift_exeparam_vaild); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL age_b_issue: got %b, required 1", shift_exeparam_vaild); end
      set_wb(7'd12, 64'h99);
      exp_q.push_back(mk(3'b010, 7'd11, 64'd7, 64'h99, 1'b0));
      step(); clr();
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL age_a_issue: got %b, required 1", shift_exeparam_vaild); end
      step();
      // X in entry0, Y in entry1; X leaves, Z reuses entry0 but is younger than Y
      set_disp(3'b100, 7'd21, 7'd30, 7'd1, 1'b0, 1'b1, 64'd0, 64'd1, 1'b0);
      step();
      set_disp(3'b001, 7'd22, 7'd20, 7'd1, 1'b0, 1'b1, 64'd0, 64'd2, 1'b0);
      step(); clr();
      set_wb(7'd30, 64'd3);
      exp_q.push_back(mk(3'b100, 7'd21, 64'd3, 64'd1, 1'b0));
      step(); clr();
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL age_x_issue: got %b, required 1", shift_exeparam_vaild); end
      set_disp(3'b010, 7'd23, 7'd20, 7'd1, 1'b0, 1'b1, 64'd0, 64'd3, 1'b0);
      step(); clr();
      set_wb(7'd20, 64'h20);
      exp_q.push_back(mk(3'b001, 7'd22, 64'h20, 64'd2, 1'b0));
      exp_q.push_back(mk(3'b010, 7'd23, 64'h20, 64'd3, 1'b0));
      step(); clr();
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL age_y_issue: got %b, required 1", shift_exeparam_vaild); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL age_z_issue: got %b, required 1", shift_exeparam_vaild); end
      step();
      vectors++; if (entry_cnt !== 3'd0) begin miscompares++; $display("FAIL age_cnt: got %0d, required 0", entry_cnt); end
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         set_disp(3'b100, TW'(30 + k), TW'(40 + k), 7'd1, 1'b0, 1'b1, 64'd0, 64'(k), 1'b0);
         step(); clr();
      end
      vectors++; if (entry_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt: got %0d, required 4", entry_cnt); end
      vectors++; if (disp_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b, required 0", disp_ready); end
      set_disp(3'b100, 7'd34, 7'd1, 7'd1, 1'b1, 1'b1, 64'd5, 64'd5, 1'b0);
      step(); clr();
      vectors++; if (entry_cnt !== 3'd4) begin miscompares++; $display("FAIL full_reject_cnt: got %0d, required 4", entry_cnt); end
      set_wb(7'd41, 64'h41);
      exp_q.push_back(mk(3'b100, 7'd31, 64'h41, 64'd1, 1'b0));
      step(); clr();
      vectors++; if (disp_ready !== 1'b0) begin miscompares++; $display("FAIL full_w1_ready: got %b, required 0", disp_ready); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL full_w2_vaild: got %b, required 1", shift_exeparam_vaild); end
      vectors++; if (disp_ready !== 1'b1) begin miscompares++; $display("FAIL full_w2_ready: got %b, required 1", disp_ready); end
      vectors++; if (entry_cnt !== 3'd3) begin miscompares++; $display("FAIL full_w2_cnt: got %0d, required 3", entry_cnt); end
   endtask

   task automatic test_flush();
      set_disp(3'b100, 7'd35, 7'd1, 7'd1, 1'b1, 1'b1, 64'd9, 64'd9, 1'b0);
      set_wb(7'd40, 64'h40);
      flush = 1'b1;
      step(); clr();
      vectors++; if (entry_cnt !== 3'd0) begin miscompares++; $display("FAIL flush_cnt: got %0d, required 0", entry_cnt); end
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL flush_vaild: got %b, required 0", shift_exeparam_vaild); end
      for (int k = 0; k < 6; k++) begin
         if (k < 3) set_wb(TW'(40 + 2 * k), 64'h77);
         step(); clr();
         vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL flush_late_issue: got %b, required 0", shift_exeparam_vaild); end
      end
   endtask

   task automatic test_bypass();
      set_disp(3'b100, 7'd15, 7'd50, 7'd2, 1'b0, 1'b1, 64'h1111, 64'd8, 1'b1);
      set_wb(7'd50, 64'hcafe);
      exp_q.push_back(mk(3'b100, 7'd15, 64'hcafe, 64'd8, 1'b1));
      step(); clr();
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL byp_t1_vaild: got %b, required 0", shift_exeparam_vaild); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL byp_t2_vaild: got %b, required 1", shift_exeparam_vaild); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [2:0] fl [3];
      fl[0] = 3'b111; fl[1] = 3'b010; fl[2] = 3'b000;
      for (int k = 0; k < 3; k++) begin
         set_disp(fl[k], TW'(60 + k), 7'd1, 7'd2, 1'b1, 1'b1, 64'(100 + k), 64'(k), k[0]);
         exp_q.push_back(mk(fl[k], TW'(60 + k), 64'(100 + k), 64'(k), k[0]));
         step();
         if (k == 1) begin
            vectors++; if (entry_cnt !== 3'd1) begin miscompares++; $display("FAIL b2b_cnt: got %0d, required 1", entry_cnt); end
         end
         if (k > 0) begin
            vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL b2b_vaild: got %b, required 1", shift_exeparam_vaild); end
         end
      end
      clr();
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b1) begin miscompares++; $display("FAIL b2b_last_vaild: got %b, required 1", shift_exeparam_vaild); end
      step();
      vectors++; if (shift_exeparam_vaild !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_vaild: got %b, required 0", shift_exeparam_vaild); end
      vectors++; if (entry_cnt !== 3'd0) begin miscompares++; $display("FAIL b2b_end_cnt: got %0d, required 0", entry_cnt); end
   endtask

   initial begin
      RST = 1'b1;
      flush = 1'b0; disp_vaild = 1'b0; wb_vaild = 1'b0;
      disp_fun = '0; disp_rd0 = '0; disp_rs1 = '0; disp_rs2 = '0;
      disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_op1 = '0; disp_op2 = '0;
      disp_is32w = 1'b0; wb_tag = '0; wb_data = '0;
      test_reset();
      test_dispatch();
      test_wakeup();
      test_age();
      test_full();
      test_flush();
      test_bypass();
      test_back_to_back();
      step();
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL missing_issues: got %0d pending, required 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
